// File: rtl/lock_pkg.sv
// lock_pkg: shared state encoding and constants for the lock controller
package lock_pkg;
  typedef enum logic [1:0] {LOCKED, CHECK, UNLOCK, LOCKOUT} state_t;
  localparam logic MODE_VERIFY = 1'b0;
  localparam logic MODE_SET = 1'b1;
  localparam logic PW_DEFAULT_BIT = 1'b0;
endpackage

// File: rtl/lock_ctrl_param_if.sv
// lock_ctrl_param_if: keypad strobes in, display/actuator status out
interface lock_ctrl_param_if #(
  parameter int DIGITS = 6,
  parameter int DIGIT_W = 4
);
  logic mode;
  logic key_valid;
  logic [DIGIT_W-1:0] key_digit;
  logic key_enter;
  logic key_clear;
  logic relock;
  logic [DIGITS*DIGIT_W-1:0] disp;
  logic [$clog2(DIGITS+1)-1:0] digit_cnt;
  logic unlock;
  logic fail;
  logic set_ok;
  logic lockout;
  modport master (
    output mode, key_valid, key_digit, key_enter, key_clear, relock,
    input disp, digit_cnt, unlock, fail, set_ok, lockout
  );
  modport slave (
    input mode, key_valid, key_digit, key_enter, key_clear, relock,
    output disp, digit_cnt, unlock, fail, set_ok, lockout
  );
endinterface

// File: rtl/lock_pw_reg.sv
// lock_pw_reg: stored password, cleared to the default on clr
module lock_pw_reg
  import lock_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int DIGIT_W = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic we,
  input  logic [DIGITS*DIGIT_W-1:0] d,
  output logic [DIGITS*DIGIT_W-1:0] q
);
  always_ff @(posedge clk)
    if (clr) q <= {(DIGITS*DIGIT_W){PW_DEFAULT_BIT}};
    else if (we) q <= d;
endmodule

// File: rtl/lock_ctrl_param.sv
// lock_ctrl_param: serial-entry lock FSM with entry buffer, fail counter and lockout timer
module lock_ctrl_param
  import lock_pkg::*;
#(
  parameter int DIGITS = 6,
  parameter int DIGIT_W = 4,
  parameter int MAX_FAIL = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic clk,
  input logic clr,
  lock_ctrl_param_if.slave bus
);
  localparam int W = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2(LOCK_CYCLES + 1);
  state_t state;
  logic [DIGITS-1:0][DIGIT_W-1:0] entry;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fail_cnt;
  logic [FW-1:0] fail_nxt;
  logic [TW-1:0] timer;
  logic [W-1:0] pw;
  logic full, match, pw_we, fail_q, set_ok_q;
  assign full = cnt == CW'(DIGITS);
  assign match = full && (entry == pw);
  assign fail_nxt = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FW'(1);
  assign pw_we = (state == UNLOCK) && !bus.key_clear && bus.key_enter && (bus.mode == MODE_SET) && full;
  lock_pw_reg #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_pw (
    .clk(clk), .clr(clr), .we(pw_we), .d(entry), .q(pw)
  );
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= LOCKED;
      entry <= '0;
      cnt <= '0;
      fail_cnt <= '0;
      timer <= '0;
      fail_q <= 1'b0;
      set_ok_q <= 1'b0;
    end else begin
      fail_q <= 1'b0;
      set_ok_q <= pw_we;
      case (state)
        LOCKED, UNLOCK: begin
          // in LOCKED the entry survives key_enter so CHECK can compare it
          if (bus.key_clear || (state == UNLOCK && (bus.key_enter || bus.relock))) begin
            entry <= '0;
            cnt <= '0;
          end else if (bus.key_enter) state <= CHECK;
          else if (bus.key_valid && !full) begin
            for (int i = 0; i < DIGITS; i++)
              if (cnt == CW'(i)) entry[i] <= bus.key_digit;
            cnt <= cnt + CW'(1);
          end
          if (state == UNLOCK && bus.relock && !bus.key_enter) state <= LOCKED;
        end
        CHECK: begin
          entry <= '0;
          cnt <= '0;
          if (match) begin
            state <= UNLOCK;
            fail_cnt <= '0;
          end else begin
            fail_q <= 1'b1;
            fail_cnt <= fail_nxt;
            state <= (fail_nxt == FW'(MAX_FAIL)) ? LOCKOUT : LOCKED;
            timer <= TW'(LOCK_CYCLES - 1);
          end
        end
        LOCKOUT:
          if (timer == '0) begin
            state <= LOCKED;
            fail_cnt <= '0;
          end else timer <= timer - TW'(1);
        default: state <= LOCKED;
      endcase
    end
  end
  assign bus.disp = entry;
  assign bus.digit_cnt = cnt;
  assign bus.unlock = state == UNLOCK;
  assign bus.lockout = state == LOCKOUT;
  assign bus.fail = fail_q;
  assign bus.set_ok = set_ok_q;
endmodule

// File: tb/tb_lock_ctrl_param.sv
// tb_lock_ctrl_param: table-driven check of the default lock plus directed runs of a 4x8 variant
module tb_lock_ctrl_param;
  logic clk = 1'b0;
  logic clr_a, clr_b;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  lock_ctrl_param_if #(.DIGITS(6), .DIGIT_W(4)) ia ();
  lock_ctrl_param_if #(.DIGITS(4), .DIGIT_W(8)) ib ();
  lock_ctrl_param #(.DIGITS(6), .DIGIT_W(4), .MAX_FAIL(3), .LOCK_CYCLES(16)) ua (
    .clk(clk), .clr(clr_a), .bus(ia)
  );
  lock_ctrl_param #(.DIGITS(4), .DIGIT_W(8), .MAX_FAIL(1), .LOCK_CYCLES(3)) ub (
    .clk(clk), .clr(clr_b), .bus(ib)
  );
  typedef struct {
    logic c, v, e, k, r, m;
    logic [3:0] d;
    logic unl, fl, so, lo;
    logic [2:0] cnt;
    logic [23:0] disp;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic c, v, e, k, r, m, input logic [3:0] d,
                     input logic unl, fl, so, lo, input logic [2:0] cnt, input logic [23:0] disp);
    vec_t x;
    x.c = c; x.v = v; x.e = e; x.k = k; x.r = r; x.m = m; x.d = d;
    x.unl = unl; x.fl = fl; x.so = so; x.lo = lo; x.cnt = cnt; x.disp = disp;
    tbl.push_back(x);
  endtask
  task automatic add_code(input logic [23:0] code, input int n, input logic m, input logic unl);
    for (int i = 0; i < n; i++) begin
      logic [23:0] msk;
      msk = (24'h1 << (4 * (i + 1))) - 24'h1;
      add(0, 1, 0, 0, 0, m, code[4*i+:4], unl, 0, 0, 0, 3'(i + 1), code & msk);
    end
  endtask
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic bs(input logic v, e, k, r, m, input logic [7:0] d);
    ib.key_valid = v; ib.key_enter = e; ib.key_clear = k; ib.relock = r; ib.mode = m; ib.key_digit = d;
    @(negedge clk);
    ib.key_valid = 0; ib.key_enter = 0; ib.key_clear = 0; ib.relock = 0; ib.mode = 0; ib.key_digit = '0;
  endtask
  task automatic b_enter(input logic [31:0] code, input logic m);
    for (int i = 0; i < 4; i++) bs(1, 0, 0, 0, m, code[8*i+:8]);
  endtask
  function automatic logic [63:0] b_all();
    return 64'({ib.unlock, ib.fail, ib.set_ok, ib.lockout, ib.digit_cnt, ib.disp});
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    logic [30:0] got, exp;
    clr_a = 1; clr_b = 1;
    ia.key_valid = 0; ia.key_enter = 0; ia.key_clear = 0; ia.relock = 0; ia.mode = 0; ia.key_digit = '0;
    ib.key_valid = 0; ib.key_enter = 0; ib.key_clear = 0; ib.relock = 0; ib.mode = 0; ib.key_digit = '0;
    repeat (2) @(negedge clk);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(24'h000000, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add_code(24'h654321, 6, 1, 1);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(24'h654321, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 24'h654321);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0, 1, 24'h4);
    add(0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(24'h000000, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_code(24'h000321, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 24'h321);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_code(24'h999999, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 24'h999999);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) add(0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    add_code(24'h654321, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 24'h654321);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(24'h654321, 6, 0, 0);
    add(0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 6, 24'h654321);
    add(0, 1, 0, 1, 0, 0, 8, 0, 0, 0, 0, 0, 0);
    add_code(24'h000033, 2, 0, 0);
    add(1, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    add_code(24'h000000, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add_code(24'h000001, 1, 0, 0);
      add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'h1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, i == 2, 0, 0);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_code(24'h000001, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 24'h1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add_code(24'h000000, 6, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      clr_a = tbl[i].c; ia.key_valid = tbl[i].v; ia.key_enter = tbl[i].e; ia.key_clear = tbl[i].k;
      ia.relock = tbl[i].r; ia.mode = tbl[i].m; ia.key_digit = tbl[i].d;
      @(negedge clk);
      got = {ia.unlock, ia.fail, ia.set_ok, ia.lockout, ia.digit_cnt, ia.disp};
      exp = {tbl[i].unl, tbl[i].fl, tbl[i].so, tbl[i].lo, tbl[i].cnt, tbl[i].disp};
      chk($sformatf("a_vec%0d", i), 64'(got), 64'(exp));
    end
    clr_a = 0; ia.key_valid = 0; ia.key_enter = 0; ia.key_clear = 0; ia.relock = 0;
    chk("b_reset", b_all(), 64'h0);
    clr_b = 0;
    b_enter(32'h0, 0);
    chk("b_cnt_full", 64'(ib.digit_cnt), 64'd4);
    bs(0, 1, 0, 0, 0, 0);
    bs(0, 0, 0, 0, 0, 0);
    chk("b_unlock_zero", 64'(ib.unlock), 64'd1);
    b_enter(32'hD4C3B2A1, 1);
    bs(1, 0, 0, 0, 1, 8'hE5);
    chk("b_overflow", 64'({ib.digit_cnt, ib.disp}), 64'({3'd4, 32'hD4C3B2A1}));
    bs(0, 1, 0, 0, 1, 0);
    chk("b_set_ok", 64'({ib.set_ok, ib.unlock, ib.digit_cnt}), 64'({1'b1, 1'b1, 3'd0}));
    bs(0, 0, 0, 1, 0, 0);
    chk("b_relock", 64'(ib.unlock), 64'd0);
    bs(1, 0, 0, 0, 0, 8'hA1);
    bs(0, 1, 0, 0, 0, 0);
    bs(0, 0, 0, 0, 0, 0);
    chk("b_fail_lockout", 64'({ib.fail, ib.lockout}), 64'({1'b1, 1'b1}));
    bs(1, 0, 0, 0, 0, 8'h11);
    chk("b_lockout2", 64'({ib.fail, ib.lockout, ib.digit_cnt}), 64'({1'b0, 1'b1, 3'd0}));
    bs(0, 0, 0, 0, 0, 0);
    chk("b_lockout3", 64'(ib.lockout), 64'd1);
    bs(0, 0, 0, 0, 0, 0);
    chk("b_lockout_end", 64'(ib.lockout), 64'd0);
    b_enter(32'hD4C3B2A1, 0);
    bs(0, 1, 0, 0, 0, 0);
    bs(0, 0, 0, 0, 0, 0);
    chk("b_unlock_new", 64'(ib.unlock), 64'd1);
    clr_b = 1;
    @(negedge clk);
    clr_b = 0;
    chk("b_clr", b_all(), 64'h0);
    b_enter(32'h0, 0);
    bs(0, 1, 0, 0, 0, 0);
    bs(0, 0, 0, 0, 0, 0);
    chk("b_pw_restored", 64'({ib.unlock, ib.fail}), 64'({1'b1, 1'b0}));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lock_ctrl_param.md
# lock_ctrl_param

Parametrised, serially-entered electronic lock controller: keypad digits shift into an entry buffer, which is compared against a stored password. A match opens the lock; repeated failures trigger a timed lockout. The password can be changed only while the lock is open. It sits between the keypad decoder and the display/actuator drivers, and generalises the fixed six-digit parallel lock to any digit count and width.

## Interface
- DIGITS, 6, number of password digits (≥1)
- DIGIT_W, 4, bits per digit
- MAX_FAIL, 3, consecutive failed attempts before lockout (≥1)
- LOCK_CYCLES, 16, lockout duration in clk cycles (≥1)
- clk  in  1  single clock, rising edge
- clr  in  1  reset, synchronous, active-high
- mode  in  1  0 = verify entry, 1 = set new password (sampled on key_enter)
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  DIGIT_W  digit value
- key_enter  in  1  one-cycle strobe, submit entry
- key_clear  in  1  one-cycle strobe, discard entry
- relock  in  1  close lock (UNLOCK → LOCKED)
- disp  out  DIGITS*DIGIT_W  entry buffer, digit 0 in LSBs, unentered digits read 0
- digit_cnt  out  $clog2(DIGITS+1)  digits entered
- unlock  out  1  lock open (level)
- fail  out  1  one-cycle pulse per rejected submission
- set_ok  out  1  one-cycle pulse, password written
- lockout  out  1  lockout active (level)

## Operation
- States: LOCKED, CHECK, UNLOCK, LOCKOUT. Reset → LOCKED. All outputs are 0, the password is all zeros, and the counters are 0.
- Input priority in LOCKED/UNLOCK: key_clear > key_enter > key_valid. Lower-priority strobes in the same cycle are dropped.
- key_valid: write key_digit to buffer slot digit_cnt, then digit_cnt+1. When digit_cnt==DIGITS, the digit is ignored (no shift, no wrap).
- key_clear: clear the buffer and set digit_cnt to 0. No other effect.
- key_enter in LOCKED:
  - Mode is ignored.
  - Go to CHECK. The buffer and digit_cnt are cleared on leaving CHECK.
- CHECK:
  - Match means digit_cnt==DIGITS and buffer==password. A short entry is always a mismatch.
  - Match: go to UNLOCK and set fail_cnt to 0.
  - Mismatch: pulse fail and increment fail_cnt. If the new fail_cnt==MAX_FAIL, go to LOCKOUT; otherwise go to LOCKED.
- UNLOCK:
  - unlock=1.
  - key_enter with mode=1 and digit_cnt==DIGITS: write the buffer to the password, pulse set_ok, stay in UNLOCK, clear the buffer.
  - key_enter with mode=0, or with a short entry: clear the buffer only.
  - relock: go to LOCKED and clear the buffer. relock has lower priority than key_enter in the same cycle.
- LOCKOUT:
  - lockout=1. All key inputs and relock are ignored, and the buffer is held at 0.
  - The timer loads LOCK_CYCLES-1 on entry and counts down. At 0: go to LOCKED and set fail_cnt to 0.
- Widths:
  - fail_cnt is $clog2(MAX_FAIL+1) bits and saturates at MAX_FAIL.
  - The timer is $clog2(LOCK_CYCLES+1) bits.
  - The comparison is an equality over all DIGITS*DIGIT_W bits.
- clr has priority over everything in every state. It also restores the password to 0.

## Timing
- key_valid at edge t: disp and digit_cnt are updated after edge t (visible in cycle t+1).
- key_enter at t: CHECK in cycle t+1. unlock, or the fail pulse, is visible in cycle t+2. lockout is visible in cycle t+2 on the MAX_FAIL-th failure.
- The lockout level lasts exactly LOCK_CYCLES cycles. LOCKED resumes in the following cycle.
- A set_ok pulse is visible in cycle t+1 after key_enter at t. A new password is effective for any CHECK from cycle t+1.
- unlock drops in the cycle after relock is sampled.
- Strobes arriving while in CHECK are ignored.

## Structure
- Package lock_pkg:
  - state enum (LOCKED, CHECK, UNLOCK, LOCKOUT)
  - MODE_VERIFY/MODE_SET constants
  - default-password constant (all zeros)
- Sub-module lock_pw_reg: parametrised password register with DIGITS, DIGIT_W, synchronous clr to zero, write enable, flat output. The top level holds the FSM, entry buffer, counters and timer.

## Test plan
- Reset, enter 0,0,0,0,0,0, key_enter → unlock=1 in cycle t+2, fail never pulses.
- In UNLOCK with mode=1, enter 1,2,3,4,5,6, key_enter → set_ok pulse; relock. Then entering 1,2,3,4,5,6 in verify mode → unlock; entering 0×6 → fail.
- Three wrong entries (including one short 1,2,3 entry) → three fail pulses. lockout=1 for exactly 16 cycles, and key_valid is ignored throughout. A correct entry afterwards unlocks.
- Seven key_valid strobes → digit_cnt=6, disp holds the first six digits. key_clear together with key_valid → digit_cnt=0.
- clr asserted mid-entry and mid-LOCKOUT → all outputs 0 next cycle, password back to zeros.
- Re-run the above with DIGITS=4, DIGIT_W=8, MAX_FAIL=1, LOCK_CYCLES=3.
